// File: rtl/cus19_crypto_pkg.sv
// Shared definitions for the cus19 ENC/DEC memory sequencer and crypto core.
package cus19_crypto_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int ROT_AMT = 3;

endpackage

// File: rtl/cus19_crypto_core.sv
// Combinational cus19 byte transform: ENC = rotl(p ^ key), DEC = rotr(c) ^ key.
module cus19_crypto_core
    import cus19_crypto_pkg::*;
#(
    parameter int                    Data_Width = 8,
    parameter logic [Data_Width-1:0] key        = 8'hA5
) (
    input  logic                  mode_i,
    input  logic [Data_Width-1:0] data_i,
    output logic [Data_Width-1:0] data_o
);

    localparam int ROT = ROT_AMT % Data_Width;

    logic [Data_Width-1:0] enc_xor;
    logic [Data_Width-1:0] enc_val;
    logic [Data_Width-1:0] dec_rot;
    logic [Data_Width-1:0] dec_val;

    assign enc_xor = data_i ^ key;
    assign enc_val = (enc_xor << ROT) | (enc_xor >> (Data_Width - ROT));
    assign dec_rot = (data_i >> ROT) | (data_i << (Data_Width - ROT));
    assign dec_val = dec_rot ^ key;

    assign data_o = (mode_i == MODE_DEC) ? dec_val : enc_val;

endmodule

// File: rtl/cus19_crypto_mem_sequencer.sv
// ENC/DEC sequencer: reads a source byte, transforms it, writes it back, while
// sharing the single data-memory port with the CPU load/store path.
//   state | meaning
//   IDLE  | waiting for start; CPU owns the port on request
//   RD    | issue source read when the sequencer wins arbitration
//   WAIT  | capture transformed read data; port free to the CPU
//   WR    | issue destination write when the sequencer wins arbitration
//   DONE  | one-cycle done pulse
module cus19_crypto_mem_sequencer
    import cus19_crypto_pkg::*;
#(
    parameter int                    Data_Width = 8,
    parameter int                    Addr_Width = 8,
    parameter logic [Data_Width-1:0] key        = 8'hA5,
    parameter int                    Max_Defer  = 3
) (
    input  logic                  cus19_clk_in,
    input  logic                  cus19_rst_in,
    input  logic                  cry_start_in,
    input  logic                  cry_mode_in,
    input  logic [Addr_Width-1:0] cry_src_addr_in,
    input  logic [Addr_Width-1:0] cry_dst_addr_in,
    output logic                  cry_busy_out,
    output logic                  cry_stall_out,
    output logic                  cry_done_out,
    input  logic                  cpu_req_in,
    input  logic                  cpu_we_in,
    input  logic [Addr_Width-1:0] cpu_addr_in,
    input  logic [Data_Width-1:0] cpu_wdata_in,
    output logic                  cpu_gnt_out,
    output logic [Data_Width-1:0] cpu_rdata_out,
    output logic                  mem_en_out,
    output logic                  mem_we_out,
    output logic [Addr_Width-1:0] mem_addr_out,
    output logic [Data_Width-1:0] mem_wdata_out,
    input  logic [Data_Width-1:0] mem_rdata_in
);

    localparam int DEFER_W = (Max_Defer < 1) ? 1 : $clog2(Max_Defer + 1);
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(Max_Defer);

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [Addr_Width-1:0] src_q, src_d;
    logic [Addr_Width-1:0] dst_q, dst_d;
    logic [Data_Width-1:0] result_q, result_d;
    logic [DEFER_W-1:0]    defer_q, defer_d;

    logic                  seq_phase;
    logic                  seq_own;
    logic [Data_Width-1:0] core_out;

    cus19_crypto_core #(
        .Data_Width (Data_Width),
        .key        (key)
    ) u_core (
        .mode_i (mode_q),
        .data_i (mem_rdata_in),
        .data_o (core_out)
    );

    // Only RD and WR contend for the port; the CPU wins until the sequencer
    // has been deferred Max_Defer cycles in a row.
    assign seq_phase   = (state_q == ST_RD) || (state_q == ST_WR);
    assign seq_own     = seq_phase && (!cpu_req_in || (defer_q == DEFER_MAX));
    assign cpu_gnt_out = cpu_req_in && !seq_own;

    assign cry_busy_out  = (state_q != ST_IDLE);
    assign cry_done_out  = (state_q == ST_DONE);
    assign cry_stall_out = cry_busy_out | cry_start_in;
    assign cpu_rdata_out = mem_rdata_in;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        result_d = result_q;
        defer_d  = defer_q;

        if (seq_phase) begin
            defer_d = seq_own ? '0 : defer_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cry_start_in) begin
                    mode_d  = cry_mode_in;
                    src_d   = cry_src_addr_in;
                    dst_d   = cry_dst_addr_in;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (seq_own) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                result_d = core_out;
                state_d  = ST_WR;
            end
            ST_WR: begin
                if (seq_own) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en_out    = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        if (seq_own) begin
            mem_en_out = 1'b1;
            if (state_q == ST_WR) begin
                mem_we_out    = 1'b1;
                mem_addr_out  = dst_q;
                mem_wdata_out = result_q;
            end else begin
                mem_addr_out  = src_q;
            end
        end else if (cpu_gnt_out) begin
            mem_en_out    = 1'b1;
            mem_we_out    = cpu_we_in;
            mem_addr_out  = cpu_addr_in;
            mem_wdata_out = cpu_wdata_in;
        end
    end

    always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
        if (!cus19_rst_in) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ENC;
            src_q    <= '0;
            dst_q    <= '0;
            result_q <= '0;
            defer_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            result_q <= result_d;
            defer_q  <= defer_d;
        end
    end

endmodule

// File: doc/cus19_crypto_mem_sequencer.md
# cus19_crypto_mem_sequencer

Multi-cycle controller for the cus19 ENC/DEC instructions. It shares the single data-memory port between the CPU load/store path and the crypto datapath. On a decoded ENC/DEC it stalls the pipeline and reads the source byte. It transforms the byte with the fixed key, writes the result to the destination address, then pulses done. It sits between decode/execute and data memory, in front of the data-memory instance.

## Interface
- `Data_Width`, 8, data-memory word width
- `Addr_Width`, 8, data-memory address width (addresses come from register values)
- `key`, 8'hA5, crypto key
- `Max_Defer`, 3, consecutive cycles the sequencer may lose arbitration before it takes priority
- `cus19_clk_in` in 1: clock; all state changes on the rising edge
- `cus19_rst_in` in 1: asynchronous, active-low reset
- `cry_start_in` in 1: one-cycle request from decode
- `cry_mode_in` in 1: 0 = ENC, 1 = DEC; sampled with start
- `cry_src_addr_in` in Addr_Width: source address; sampled with start
- `cry_dst_addr_in` in Addr_Width: destination address; sampled with start
- `cry_busy_out` out 1: high in every non-IDLE state
- `cry_stall_out` out 1: combinational, `cry_busy_out | cry_start_in`; holds PC and pipeline
- `cry_done_out` out 1: one-cycle pulse in DONE
- `cpu_req_in` in 1: CPU LD/ST wants the memory this cycle
- `cpu_we_in` in 1: CPU write enable
- `cpu_addr_in` in Addr_Width: CPU address
- `cpu_wdata_in` in Data_Width: CPU write data
- `cpu_gnt_out` out 1: combinational; CPU owns the port this cycle
- `cpu_rdata_out` out Data_Width: passthrough of `mem_rdata_in`
- `mem_en_out` out 1: memory access enable
- `mem_we_out` out 1: memory write enable
- `mem_addr_out` out Addr_Width: memory address
- `mem_wdata_out` out Data_Width: memory write data
- `mem_rdata_in` in Data_Width: synchronous-read data, valid the cycle after a read is issued

## Operation
- States:
  - IDLE: on start, latch mode, src and dst, then go to RD.
  - RD: when the sequencer owns the port, issue read of src, then go to WAIT. Otherwise stay in RD.
  - WAIT: register `crypto_core(mem_rdata_in)` into the result register, then go to WR. Memory is free to the CPU.
  - WR: when the sequencer owns the port, write result to dst, then go to DONE. Otherwise stay in WR.
  - DONE: pulse done, then go to IDLE.
- Transform:
  - ENC: c = rotl3(p ^ key).
  - DEC: p = rotr3(c) ^ key.
  - Rotates are modulo Data_Width.
  - DEC(ENC(x)) = x for all x.
- Arbitration (RD/WR only; in every other state the CPU owns the port whenever it requests):
  - `cpu_req_in` wins unless `defer_cnt == Max_Defer`.
  - `defer_cnt` increments on each cycle the sequencer loses.
  - `defer_cnt` clears whenever the sequencer wins.
  - `Max_Defer = 0` means the sequencer always wins.
- Port mux:
  - Sequencer owner: drives its address and data, `mem_en` = 1.
  - CPU owner: drives cpu_* fields.
  - Otherwise: all `mem_*` outputs are 0.
- `cpu_gnt_out` is low when `cpu_req_in` is low.
- Start while busy is ignored: no state or latch change. Start on the DONE cycle is also ignored; the next start is accepted in IDLE only.
- src == dst is legal (in-place transform).

## Timing
- Reset values: state IDLE; `defer_cnt`, latches and result register 0; all outputs 0 (`cry_stall_out` follows `cry_start_in`).
- Reset assertion mid-operation: immediate return to IDLE. No write is issued after the reset edge. A partial result is discarded.
- Uncontended latency, with start sampled at edge T:
  - RD in cycle T+1
  - WAIT in T+2
  - WR in T+3 (the only cycle with `mem_we` from the sequencer)
  - DONE in T+4
  - busy high T+1..T+4
- CPU read data is valid on `cpu_rdata_out` the cycle after the grant with `cpu_we_in` = 0.
- A CPU read granted during WAIT does not disturb the captured result: the sequencer's read data is consumed in WAIT, and the CPU read data arrives in WR.

## Structure
- Package `cus19_crypto_pkg`:
  - state enum (IDLE, RD, WAIT, WR, DONE)
  - MODE_ENC/MODE_DEC constants
  - rotate amount 3
- Sub-module `cus19_crypto_core`: combinational ENC/DEC transform with `key` and `Data_Width` parameters. It is reused by other crypto paths.
- The top holds the FSM, the defer counter, the latches and the port mux.

## Test plan
- Reset low for 2 cycles, then released -> every output 0, state IDLE, `cry_stall_out` 0.
- ENC, src=10 (mem=0x0D), dst=5, no CPU traffic -> `mem[5]` = 0x45, `mem_we` high only in T+3, done pulse at T+4.
- DEC, src=13 (mem=0x3C), dst=15 -> `mem[15]` = 0x22. A follow-up ENC from 15 back to 16 gives `mem[16]` = 0x3C.
- `cpu_req_in` held high throughout an ENC, Max_Defer=3:
  - RD loses T+1..T+3 and wins T+4.
  - WAIT at T+5.
  - WR loses T+6..T+8 and wins T+9.
  - DONE at T+10.
  - `cpu_gnt_out` low exactly at T+4 and T+9.
- Second start at T+2 with a different src/dst -> ignored. Only the first transfer completes, with one done pulse.
- Reset asserted during WAIT -> no write to dst, outputs 0. A fresh ENC after release completes normally in 4 cycles.
